// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer_if : execute-stage request / HI-LO result bundle
// Revision 1.0
// ============================================================================
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [5:0]       func;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output valid, func, rs_val, rt_val,
        input  hi, lo, busy, stall, done
    );

    modport slave (
        input  valid, func, rs_val, rt_val,
        output hi, lo, busy, stall, done
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : 32-step shift-add multiply / restoring divide, owns HI/LO
// Revision 1.0
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    muldiv_sequencer_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor
    logic [2*WIDTH-1:0] acc;        // {partial product, multiplier} or {remainder, quotient}
    logic               neg_lo;     // negate product / quotient
    logic               neg_hi;     // negate remainder
    logic               is_div;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               hilo_func;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               sgn_div;

    always_comb begin
        hilo_func = 1'b0;
        case (bus.func)
            F_MULT, F_MULTU, F_DIV, F_DIVU,
            F_MFHI, F_MTHI, F_MFLO, F_MTLO: hilo_func = 1'b1;
            default:                        hilo_func = 1'b0;
        endcase
    end

    always_comb begin
        rs_mag    = bus.rs_val[WIDTH-1] ? -bus.rs_val : bus.rs_val;
        rt_mag    = bus.rt_val[WIDTH-1] ? -bus.rt_val : bus.rt_val;
        // A zero divisor keeps the raw dividend so it lands unchanged in HI
        sgn_div   = (bus.func == F_DIV) && (bus.rt_val != '0);

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];

        fix_hi    = '0;
        fix_lo    = '0;
        if (is_div) begin
            fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_lo ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
        end else begin
            {fix_hi, fix_lo} = neg_lo ? -acc : acc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            opnd   <= '0;
            acc    <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            is_div <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        case (bus.func)
                            F_MULT, F_MULTU: begin
                                opnd   <= (bus.func == F_MULT) ? rs_mag : bus.rs_val;
                                acc    <= {{WIDTH{1'b0}}, ((bus.func == F_MULT) ? rt_mag : bus.rt_val)};
                                neg_lo <= (bus.func == F_MULT) &&
                                          (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                                neg_hi <= 1'b0;
                                is_div <= 1'b0;
                                count  <= '0;
                                busy_q <= 1'b1;
                                state  <= MUL;
                            end
                            F_DIV, F_DIVU: begin
                                opnd   <= sgn_div ? rt_mag : bus.rt_val;
                                acc    <= {{WIDTH{1'b0}}, (sgn_div ? rs_mag : bus.rs_val)};
                                neg_lo <= sgn_div && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                                neg_hi <= sgn_div && bus.rs_val[WIDTH-1];
                                is_div <= 1'b1;
                                count  <= '0;
                                busy_q <= 1'b1;
                                state  <= DIV;
                            end
                            F_MTHI:  hi_q <= bus.rs_val;
                            F_MTLO:  lo_q <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) state <= FIX;
                end
                DIV: begin
                    acc   <= {div_rem, acc[WIDTH-2:0], div_ge};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & bus.valid & hilo_func;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// Randomized and directed bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    localparam int W = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    muldiv_sequencer_if #(.WIDTH(W)) bus();
    muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Result {HI, LO} straight from the architectural definition
    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'b0;
        case (f)
            F_MULT:  res = 64'(sa * sb);
            F_MULTU: res = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            F_DIVU:  res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: res = 64'b0;
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.valid = 1'b1; bus.func = f; bus.rs_val = a; bus.rt_val = b;
        #1;
        vectors++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL start_stall func=%b got=%b want=0", f, bus.stall);
        end
        {exp_hi, exp_lo} = ref_model(f, a, b);
        tick();
        bus.valid = 1'b0; bus.rs_val = $urandom; bus.rt_val = $urandom;
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL start_busy got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
        end
    endtask

    task automatic finish_op(input string name, input bit hold_mf, input int pre);
        int cycles = pre;
        if (hold_mf) begin bus.valid = 1'b1; bus.func = F_MFHI; end
        while (bus.busy === 1'b1 && cycles < 100) begin
            if (hold_mf) begin
                #1;
                vectors++;
                if (bus.stall !== 1'b1) begin
                    errors++; $display("FAIL %s busy_stall cycle=%0d got=%b want=1", name, cycles, bus.stall);
                end
            end
            cycles++;
            tick();
        end
        vectors++;
        if (cycles != W + 1) begin
            errors++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, cycles, W + 1);
        end
        vectors++;
        if (bus.done !== 1'b1) begin
            errors++; $display("FAIL %s done got=%b want=1", name, bus.done);
        end
        vectors++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++; $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h", name, bus.hi, bus.lo, exp_hi, exp_lo);
        end
        if (hold_mf) begin
            #1;
            vectors++;
            if (bus.stall !== 1'b0) begin
                errors++; $display("FAIL %s done_stall got=%b want=0", name, bus.stall);
            end
        end
        bus.valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.valid = 1'b1; bus.func = F_MFHI; bus.rs_val = '0; bus.rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b stall=%b want all 0",
                               bus.hi, bus.lo, bus.busy, bus.done, bus.stall);
        end
        bus.valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_multu();
        start_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 1'b0, 0);
        vectors++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_const got hi=%h lo=%h want hi=fffffffe lo=00000001", bus.hi, bus.lo);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL done_width got=%b want=0", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        start_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
        finish_op("mult_neg", 1'b0, 0);
        vectors++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mult_neg_const got hi=%h lo=%h want hi=ffffffff lo=ffffffeb", bus.hi, bus.lo);
        end
        start_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg", 1'b0, 0);
        vectors++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_neg_const got hi=%h lo=%h want hi=ffffffff lo=fffffffd", bus.hi, bus.lo);
        end
        tick();
    endtask

    task automatic test_div_edges();
        start_op(F_DIVU, 32'd100, 32'd0);
        finish_op("divu_zero", 1'b0, 0);
        vectors++;
        if (bus.hi !== 32'h0000_0064 || bus.lo !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL divu_zero_const got hi=%h lo=%h want hi=00000064 lo=ffffffff", bus.hi, bus.lo);
        end
        start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 1'b0, 0);
        vectors++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin
            errors++; $display("FAIL div_ovf_const got hi=%h lo=%h want hi=00000000 lo=80000000", bus.hi, bus.lo);
        end
        start_op(F_DIV, 32'hFFFF_FF9C, 32'd0);
        finish_op("div_zero_neg", 1'b0, 0);
        tick();
    endtask

    task automatic test_stall();
        start_op(F_MULT, 32'h0001_2345, 32'hFFFF_0003);
        finish_op("mult_stall", 1'b1, 0);
        tick();
    endtask

    task automatic test_move();
        logic [W-1:0] keep_lo;
        bus.valid = 1'b1; bus.func = F_MTHI; bus.rs_val = 32'h1234_5678; bus.rt_val = $urandom;
        #1;
        vectors++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL mthi_stall got=%b want=0", bus.stall);
        end
        tick();
        exp_hi = 32'h1234_5678;
        bus.func = F_MTLO; bus.rs_val = 32'hCAFE_F00D;
        vectors++;
        if (bus.hi !== exp_hi || bus.busy !== 1'b0 || bus.lo !== exp_lo) begin
            errors++; $display("FAIL mthi got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", bus.hi, bus.lo, bus.busy, exp_hi, exp_lo);
        end
        tick();
        exp_lo = 32'hCAFE_F00D;
        bus.func = F_MFLO; bus.rs_val = 32'h0BAD_0BAD;
        vectors++;
        if (bus.lo !== exp_lo || bus.hi !== exp_hi) begin
            errors++; $display("FAIL mtlo got hi=%h lo=%h want hi=%h lo=%h", bus.hi, bus.lo, exp_hi, exp_lo);
        end
        tick();
        vectors++;
        if (bus.lo !== exp_lo || bus.hi !== exp_hi || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mflo_idle got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", bus.hi, bus.lo, bus.busy, exp_hi, exp_lo);
        end
        keep_lo = exp_lo;
        start_op(F_MULTU, 32'd1000, 32'd3000);
        bus.valid = 1'b1; bus.func = F_ADD;
        #1;
        vectors++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL other_func_stall got=%b want=0", bus.stall);
        end
        tick();
        bus.func = F_MTLO; bus.rs_val = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL mtlo_busy_stall got=%b want=1", bus.stall);
        end
        tick();
        bus.valid = 1'b0;
        vectors++;
        if (bus.lo !== keep_lo) begin
            errors++; $display("FAIL mtlo_while_busy got lo=%h want %h", bus.lo, keep_lo);
        end
        finish_op("multu_small", 1'b0, 2);
        tick();
    endtask

    task automatic test_reset_abort();
        start_op(F_MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        vectors++;
        if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL abort got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", bus.hi, bus.lo, bus.busy, bus.done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL abort_hold got done=%b busy=%b want 0 0", bus.done, bus.busy);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        start_op(F_DIVU, 32'd9, 32'd4);
        finish_op("divu_after_reset", 1'b0, 0);
        vectors++;
        if (bus.hi !== 32'd1 || bus.lo !== 32'd2) begin
            errors++; $display("FAIL divu_9_4 got hi=%h lo=%h want hi=1 lo=2", bus.hi, bus.lo);
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] f;
        logic [W-1:0] a, b;
        bit chained = 1'b0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: f = F_MULT;
                1: f = F_MULTU;
                2: f = F_DIV;
                default: f = F_DIVU;
            endcase
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = W'($urandom_range(1, 15));
                default: ;
            endcase
            if (!chained) repeat ($urandom_range(0, 2)) tick();
            start_op(f, a, b);
            finish_op("random", 1'b0, 0);
            chained = ($urandom_range(0, 1) == 1);
            if (!chained) begin
                tick();
                vectors++;
                if (bus.done !== 1'b0) begin
                    errors++; $display("FAIL random_done_width got=%b want=0", bus.done);
                end
            end
        end
        tick();
    endtask

    initial begin
        bus.valid = 1'b0; bus.func = '0; bus.rs_val = '0; bus.rt_val = '0;
        test_reset();
        test_multu();
        test_back_to_back();
        test_div_edges();
        test_stall();
        test_move();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
